// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode/BIOS constants and the fetch FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_stage_pkg;

  localparam int         FETCH_PC_WIDTH    = 26;
  localparam int         FETCH_BIOS_SIZE   = 51;
  localparam logic [5:0] FETCH_HALT_OPCODE = 6'b111111;

  // Opcode field bounds within a 32-bit instruction word.
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  typedef enum logic [1:0] {
    FETCH_BOOT   = 2'd0,
    FETCH_RUN    = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch FSM and next-PC mux: picks the instruction source and decides load/bubble/hold per edge.
// Latency: pc and state update on the edge; load/bubble are combinational for the same edge.
// Backpressure: stall holds pc and state; redirect overrides stall; halt/fault only act on unstalled fetches.
//
// Ports: clock/reset (sync, active-high); stall, redirect, redirect_pc from downstream;
// bios_instr/mem_instr read data for pc; pc, fetch_word (selected source), load/bubble
// (output-register control), bios_mode, halted, fault (all registered).
module fetch_ctrl
  import fetch_stage_pkg::*;
#(
  parameter int         PC_WIDTH    = FETCH_PC_WIDTH,
  parameter int         BIOS_SIZE   = FETCH_BIOS_SIZE,
  parameter logic [5:0] HALT_OPCODE = FETCH_HALT_OPCODE
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic [31:0]         bios_instr,
  input  logic [31:0]         mem_instr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [31:0]         fetch_word,
  output logic                load,
  output logic                bubble,
  output logic                bios_mode,
  output logic                halted,
  output logic                fault
);

  fetch_state_t        state;
  fetch_state_t        state_nxt;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic                fault_set;
  logic                is_halt;
  logic                out_of_range;

  assign fetch_word   = (state == FETCH_BOOT) ? bios_instr : mem_instr;
  assign is_halt      = (fetch_word[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
  assign out_of_range = (pc >= PC_WIDTH'(BIOS_SIZE));

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    fault_set = 1'b0;
    load      = 1'b0;
    bubble    = 1'b0;
    case (state)
      FETCH_BOOT: begin
        if (redirect) begin
          pc_nxt = redirect_pc;
          bubble = 1'b1;
        end else if (!stall) begin
          // Range check first: the BIOS word at an invalid address is meaningless.
          if (out_of_range) begin
            fault_set = 1'b1;
            state_nxt = FETCH_HALTED;
            bubble    = 1'b1;
          end else if (is_halt) begin
            // BIOS handoff: swallow the halt and restart at program address 0.
            state_nxt = FETCH_RUN;
            pc_nxt    = '0;
            bubble    = 1'b1;
          end else begin
            load   = 1'b1;
            pc_nxt = pc + PC_WIDTH'(1);
          end
        end
      end
      FETCH_RUN: begin
        if (redirect) begin
          pc_nxt = redirect_pc;
          bubble = 1'b1;
        end else if (!stall) begin
          // A program halt is still delivered to decode, then fetch stops.
          load   = 1'b1;
          pc_nxt = pc + PC_WIDTH'(1);
          if (is_halt) state_nxt = FETCH_HALTED;
        end
      end
      FETCH_HALTED: bubble = 1'b1;
      default: begin
        state_nxt = FETCH_HALTED;
        bubble    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FETCH_BOOT;
      pc        <= '0;
      fault     <= 1'b0;
      bios_mode <= 1'b1;
      halted    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      if (fault_set) fault <= 1'b1;
      bios_mode <= (state_nxt == FETCH_BOOT);
      halted    <= (state_nxt == FETCH_HALTED);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns pc, selects BIOS/program source, registers one instruction per cycle to decode.
// Latency: instr_out valid one edge after pc presents its address; redirect/handoff insert one bubble.
// Backpressure: stall holds pc and the output register; redirect wins over stall.
//
// Ports: clock/reset (sync, active-high); stall, redirect, redirect_pc; bios_instr, mem_instr
// (combinational reads of pc); pc; instr_out/instr_pc/instr_valid to decode; bios_mode, halted,
// fault (sticky). Optional macro FETCH_ICOUNT_EN adds icount: saturating count of RUN fetches.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int         PC_WIDTH    = FETCH_PC_WIDTH,
  parameter int         BIOS_SIZE   = FETCH_BIOS_SIZE,
  parameter logic [5:0] HALT_OPCODE = FETCH_HALT_OPCODE
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic [31:0]         bios_instr,
  input  logic [31:0]         mem_instr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [31:0]         instr_out,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  output logic                bios_mode,
  output logic                halted,
  output logic                fault
`ifdef FETCH_ICOUNT_EN
  ,
  output logic [31:0]         icount
`endif
);

  logic [31:0] fetch_word;
  logic        load;
  logic        bubble;

  fetch_ctrl #(
    .PC_WIDTH    (PC_WIDTH),
    .BIOS_SIZE   (BIOS_SIZE),
    .HALT_OPCODE (HALT_OPCODE)
  ) u_ctrl (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bios_instr  (bios_instr),
    .mem_instr   (mem_instr),
    .pc          (pc),
    .fetch_word  (fetch_word),
    .load        (load),
    .bubble      (bubble),
    .bios_mode   (bios_mode),
    .halted      (halted),
    .fault       (fault)
  );

  // Fetch/decode pipeline register; neither load nor bubble means hold (stall).
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (load) begin
      instr_out   <= fetch_word;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
    end else if (bubble) begin
      instr_valid <= 1'b0;
    end
  end

`ifdef FETCH_ICOUNT_EN
  // bios_mode/halted both low means the FSM is in RUN this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      icount <= '0;
    end else if (load && !bios_mode && !halted && (icount != 32'hFFFF_FFFF)) begin
      icount <= icount + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage sitting directly upstream of decode and driving the address port of the BIOS ROM and of the program instruction memory. It owns the program counter, selects the instruction source according to boot mode, registers one instruction per cycle into the fetch/decode pipeline register, and applies redirects from execute. It also handles the BIOS-to-program handoff on the BIOS `halt`, and the final stop on a program `halt`.

## Interface
Parameters:
- `PC_WIDTH`, 26: program counter / ROM address width.
- `BIOS_SIZE`, 51: number of valid BIOS words; addresses `>= BIOS_SIZE` in boot mode are a fault.
- `HALT_OPCODE`, 6'b111111: opcode (bits 31:26) treated as halt.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: decode cannot accept; hold PC and the output register.
- `redirect` in 1: execute requests a jump (`j`/`jal`/`jr`/`jf` taken).
- `redirect_pc` in `PC_WIDTH`: redirect target.
- `bios_instr` in 32: combinational BIOS read data for `pc`.
- `mem_instr` in 32: combinational program-memory read data for `pc`.
- `pc` out `PC_WIDTH`: current fetch address, fed to both memories.
- `instr_out` out 32: registered instruction to decode.
- `instr_pc` out `PC_WIDTH`: address `instr_out` was fetched from.
- `instr_valid` out 1: `instr_out` is a real instruction, not a bubble.
- `bios_mode` out 1: high while in BOOT.
- `halted` out 1: high in HALTED.
- `fault` out 1: sticky; boot fetch outside the BIOS range.

## Operation
FSM states:
- **BOOT**: source is `bios_instr`.
  - Fetched word with halt opcode: not forwarded (`instr_valid`=0). Next state RUN, `pc` <= 0.
  - `pc >= BIOS_SIZE`: `fault` <= 1, next state HALTED, no valid output.
- **RUN**: source is `mem_instr`.
  - Fetched word with halt opcode: forwarded with `instr_valid`=1, then HALTED.
- **HALTED**: `pc` frozen, `instr_valid`=0. Exit only by `reset`.

Per-cycle priority (rising edge):
1. `reset`
2. `redirect`
3. `stall`
4. normal fetch

- `redirect`: `pc` <= `redirect_pc`, `instr_valid` <= 0 (one bubble). Overrides `stall` and any halt detected in the same cycle. No effect in HALTED.
- `stall` without redirect: `pc`, `instr_out`, `instr_pc`, `instr_valid` all hold.
- Normal fetch: `instr_out` <= selected word, `instr_pc` <= `pc`, `instr_valid` <= 1, `pc` <= `pc`+1, modulo 2^`PC_WIDTH`. Wrap from all-ones to 0 is silent.

## Timing
- Reset values: state BOOT, `pc`=0, `instr_out`=0, `instr_pc`=0, `instr_valid`=0, `bios_mode`=1, `halted`=0, `fault`=0.
- Memory read is combinational on `pc`. An instruction appears on `instr_out` one cycle after `pc` presents its address.
- Redirect: the target instruction is valid on `instr_out` 2 edges after the edge that samples `redirect`.
- BOOT→RUN handoff costs exactly 1 bubble. `mem_instr[0]` is valid 2 edges after the halt edge.
- `reset` asserted mid-operation: all state returns to reset values on that edge, regardless of `stall`/`redirect`.
- Halt detection is combinational on the selected word. It is ignored while `stall`=1, and the halt is re-evaluated when the stall clears.

## Configuration
- Macro `FETCH_ICOUNT_EN`.
- **Defined**: adds output `icount` (32 bits) counting edges on which `instr_valid` is written to 1 in RUN.
  - Reset to 0 with `reset`; BOOT fetches are not counted.
  - Saturates at 32'hFFFF_FFFF.
- **Undefined**: port and counter absent.
- Behaviour is otherwise identical.

## Structure
- Shared package:
  - FSM state enum (`FETCH_BOOT`, `FETCH_RUN`, `FETCH_HALTED`).
  - `HALT_OPCODE`, opcode field bounds [31:26], `PC_WIDTH`, `BIOS_SIZE` constants.
  - These are reused by decode and the BIOS.
- One natural sub-module: `fetch_ctrl`, the FSM plus next-PC mux. The top holds the pipeline register and the optional counter.

## Test plan
- Reset, BIOS model returns `addi` words, then halt at address 50. Required:
  - `instr_pc` steps 0..49 with `instr_valid`=1.
  - Halt is not forwarded; `bios_mode` falls; `pc`=0; `mem_instr[0]` is valid 2 edges later.
- RUN, `redirect`=1 with `redirect_pc`=0x2C while `stall`=1. Required: one bubble, then `instr_pc`=0x2C; the stall does not block the redirect.
- RUN, `stall` held 3 cycles at `pc`=5. Required: `pc`=5 and `instr_out` unchanged throughout; `instr_pc`=5 on the first edge after release.
- RUN, `mem_instr`=32'hFC00_0000 at `pc`=7. Required: forwarded with `instr_valid`=1, then `halted`=1, `pc` stays 8, `instr_valid`=0; with `FETCH_ICOUNT_EN`, `icount`=8.
- BOOT, redirect to `pc`=51. Required: `fault`=1 and `halted`=1 next edge; no valid output.
- `reset` pulsed during RUN at `pc`=0x100. Required: all outputs at reset values on the next edge, `bios_mode`=1.
